// File: rtl/i2cmb_cmd_queue.sv
// i2cmb_cmd_queue: command queue and sequencer between the Wishbone register
// front-end and the I2C byte-level FSM. Software pushes byte-level commands;
// the sequencer issues them one at a time, waits for completion, tracks the
// last status, and halts with an interrupt on any failure.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   cmd_valid/ready/op/data push side (op: 0 START,1 STOP,2 RD_ACK,3 RD_NAK,
//                           4 WRITE,5 SET_BUS, 6/7 illegal)
//   exec_valid/ready/op/data/bus  command offered to byte FSM
//   rsp_valid/status/data   byte FSM completion (0 DONE,1 NAK,2 ARB,3 ERR)
//   last_status_o           0 NONE,1 DONE,2 NAK,3 ARB_LOST,4 ERROR,
//                           5 TIMEOUT,6 BAD_BUS,7 BAD_OP
//   rd_data_o, level_o, halted_o, irq_o, irq_ack_i
module i2cmb_cmd_queue #(
  parameter int DEPTH     = 8,
  parameter int NUM_BUSES = 16,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [2:0]                   cmd_op_i,
  input  logic [DATA_W-1:0]            cmd_data_i,
  output logic                         exec_valid_o,
  input  logic                         exec_ready_i,
  output logic [2:0]                   exec_op_o,
  output logic [DATA_W-1:0]            exec_data_o,
  output logic [7:0]                   exec_bus_o,
  input  logic                         rsp_valid_i,
  input  logic [1:0]                   rsp_status_i,
  input  logic [DATA_W-1:0]            rsp_data_i,
  output logic [2:0]                   last_status_o,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         halted_o,
  output logic                         irq_o,
  input  logic                         irq_ack_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [2:0] OP_RD_ACK  = 3'd2;
  localparam logic [2:0] OP_RD_NAK  = 3'd3;
  localparam logic [2:0] OP_SET_BUS = 3'd5;

  localparam logic [2:0] ST_TIMEOUT = 3'd5;
  localparam logic [2:0] ST_BAD_BUS = 3'd6;
  localparam logic [2:0] ST_BAD_OP  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t state_q, state_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]            wr_ptr, rd_ptr, wr_vis;
  logic [DATA_W+2:0]      mem [DEPTH];
  logic [DATA_W+2:0]      head;
  logic [2:0]             head_op;
  logic [DATA_W-1:0]      head_data;
  logic                   full, avail, push;
  logic                   alive_q;

  logic [2:0]             exec_op_q;
  logic [DATA_W-1:0]      exec_data_q;
  logic [7:0]             bus_q;
  logic [2:0]             status_q;
  logic [DATA_W-1:0]      rd_data_q;
  logic                   irq_q;
  logic [TIMEOUT_W-1:0]   wd_q;

  logic pop, flush, ld_exec, ld_bus, st_ld, rd_ld, wd_clr, wd_inc, irq_set;
  logic [2:0] st_d;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_op   = head[DATA_W+2:DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign level_o   = LW'(wr_ptr - rd_ptr);
  assign full      = (level_o == LW'(DEPTH));
  // The sequencer sees the write pointer one cycle late (registered head
  // read), giving the two-cycle push-to-issue latency.
  assign avail     = (wr_vis != rd_ptr);

  assign cmd_ready_o   = alive_q && !full && (state_q != S_HALT);
  assign push          = cmd_valid_i && cmd_ready_o;
  assign exec_valid_o  = (state_q == S_ISSUE);
  assign exec_op_o     = exec_op_q;
  assign exec_data_o   = exec_data_q;
  assign exec_bus_o    = bus_q;
  assign last_status_o = status_q;
  assign rd_data_o     = rd_data_q;
  assign halted_o      = (state_q == S_HALT);
  assign irq_o         = irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop = 1'b0; flush = 1'b0; ld_exec = 1'b0; ld_bus = 1'b0;
    st_ld = 1'b0; st_d = status_q; rd_ld = 1'b0;
    wd_clr = 1'b0; wd_inc = 1'b0; irq_set = 1'b0;
    case (state_q)
      S_IDLE: if (avail) begin
        pop = 1'b1;
        if (head_op == OP_SET_BUS) begin
          if (32'(head_data) < NUM_BUSES) ld_bus = 1'b1;
          else begin st_ld = 1'b1; st_d = ST_BAD_BUS; state_d = S_HALT; end
        end else if (head_op > OP_SET_BUS) begin
          st_ld = 1'b1; st_d = ST_BAD_OP; state_d = S_HALT;
        end else begin
          ld_exec = 1'b1; state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (exec_ready_i) begin
        wd_clr = 1'b1; state_d = S_WAIT;
      end
      S_WAIT: if (rsp_valid_i) begin
        // A response in the watchdog's final cycle takes priority.
        st_ld = 1'b1;
        st_d  = {1'b0, rsp_status_i} + 3'd1;
        if (rsp_status_i == 2'd0) begin
          state_d = S_IDLE;
          rd_ld   = (exec_op_q == OP_RD_ACK) || (exec_op_q == OP_RD_NAK);
          irq_set = (level_o == '0) && !push;
        end else begin
          state_d = S_HALT;
        end
      end else if (wd_q == TIMEOUT_W'(TIMEOUT - 1)) begin
        st_ld = 1'b1; st_d = ST_TIMEOUT; state_d = S_HALT;
      end else begin
        wd_inc = 1'b1;
      end
      S_HALT: if (irq_ack_i) begin
        flush = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_HALT && state_q != S_HALT) irq_set = 1'b1;
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op_i, cmd_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0; rd_ptr <= '0; wr_vis <= '0; alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      wr_vis  <= wr_ptr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Pushes are refused in HALT, so the flush never races a write.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      exec_op_q <= '0; exec_data_q <= '0; bus_q <= '0; status_q <= '0;
      rd_data_q <= '0; irq_q <= 1'b0; wd_q <= '0;
    end else begin
      if (ld_exec) begin
        exec_op_q   <= head_op;
        exec_data_q <= head_data;
      end
      if (ld_bus) bus_q <= 8'(head_data);
      if (st_ld)  status_q <= st_d;
      if (rd_ld)  rd_data_q <= rsp_data_i;
      if (wd_clr)      wd_q <= '0;
      else if (wd_inc) wd_q <= wd_q + 1'b1;
      if (irq_set)        irq_q <= 1'b1;
      else if (irq_ack_i) irq_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2cmb_cmd_queue.sv
module tb_i2cmb_cmd_queue;
  localparam int DEPTH = 8;
  localparam int NB    = 16;
  localparam int DW    = 8;
  localparam int TO    = 10;
  localparam int LW    = $clog2(DEPTH+1);

  localparam logic [2:0] OP_START = 3'd0, OP_STOP = 3'd1, OP_RD_NAK = 3'd3,
                         OP_WRITE = 3'd4, OP_SET_BUS = 3'd5;

  logic          clk_i = 1'b0, rst_n_i = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o;
  logic [2:0]    cmd_op_i = '0;
  logic [DW-1:0] cmd_data_i = '0;
  logic          exec_valid_o, exec_ready_i = 1'b0;
  logic [2:0]    exec_op_o;
  logic [DW-1:0] exec_data_o;
  logic [7:0]    exec_bus_o;
  logic          rsp_valid_i = 1'b0;
  logic [1:0]    rsp_status_i = '0;
  logic [DW-1:0] rsp_data_i = '0;
  logic [2:0]    last_status_o;
  logic [DW-1:0] rd_data_o;
  logic [LW-1:0] level_o;
  logic          halted_o, irq_o, irq_ack_i = 1'b0;

  i2cmb_cmd_queue #(.DEPTH(DEPTH), .NUM_BUSES(NB), .DATA_W(DW),
                    .TIMEOUT_W(16), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i),
    .exec_op_o(exec_op_o), .exec_data_o(exec_data_o), .exec_bus_o(exec_bus_o),
    .rsp_valid_i(rsp_valid_i), .rsp_status_i(rsp_status_i),
    .rsp_data_i(rsp_data_i), .last_status_o(last_status_o),
    .rd_data_o(rd_data_o), .level_o(level_o), .halted_o(halted_o),
    .irq_o(irq_o), .irq_ack_i(irq_ack_i));

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [2:0] op; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [DW-1:0] d, input bit expect_issue);
    bit acc = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_data_i = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready_o) begin step(); acc = 1; break; end
      step();
    end
    cmd_valid_i = 1'b0;
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: op %0d not accepted within bound", op);
    end else if (expect_issue) exp_q.push_back('{op: op, data: d});
  endtask

  task automatic wait_issue(output logic [2:0] op, output logic [DW-1:0] d, output logic [7:0] bus);
    bit got = 0;
    op = 'x; d = 'x; bus = 'x;
    exec_ready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exec_valid_o) begin
        op = exec_op_o; d = exec_data_o; bus = exec_bus_o;
        step(); got = 1; break;
      end
      step();
    end
    exec_ready_i = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: no exec_valid_o within bound");
    end
  endtask

  task automatic respond(input logic [1:0] st, input logic [DW-1:0] d);
    rsp_valid_i = 1'b1; rsp_status_i = st; rsp_data_i = d;
    step();
    rsp_valid_i = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", cmd_ready_o); end
    n_cmp++; if ({exec_valid_o, halted_o, irq_o, level_o, last_status_o, exec_bus_o, rd_data_o} !== '0) begin
      n_fail++; $display("FAIL rst_outputs: ev%b h%b i%b lvl%0d st%0d bus%0d rd%h want all 0",
        exec_valid_o, halted_o, irq_o, level_o, last_status_o, exec_bus_o, rd_data_o); end
    rst_n_i = 1'b1;
    step();
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_latency();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b; exp_t e;
    push_cmd(OP_START, 8'h00, 1);
    step();
    n_cmp++; if (exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got %b want 0", exec_valid_o); end
    step();
    n_cmp++; if (exec_valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_n2: got %b want 1", exec_valid_o); end
    wait_issue(op, d, b);
    e = exp_q.pop_front();
    n_cmp++; if (op !== e.op) begin n_fail++; $display("FAIL lat_op: got %0d want %0d", op, e.op); end
    respond(2'd0, 8'h00);
    ack_irq();
  endtask

  task automatic test_sequence();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b; exp_t e;
    push_cmd(OP_START, 8'h00, 1);
    push_cmd(OP_WRITE, 8'hA0, 1);
    push_cmd(OP_RD_NAK, 8'h00, 1);
    push_cmd(OP_STOP, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      wait_issue(op, d, b);
      e = exp_q.pop_front();
      n_cmp++; if ({op, d} !== {e.op, e.data}) begin
        n_fail++; $display("FAIL seq_issue%0d: got op%0d d%h want op%0d d%h", i, op, d, e.op, e.data); end
      if (i == 3) begin
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL seq_irq_early: got %b want 0", irq_o); end
      end
      respond(2'd0, (op == OP_RD_NAK) ? 8'h5C : 8'h11);
    end
    n_cmp++; if (rd_data_o !== 8'h5C) begin n_fail++; $display("FAIL seq_rd_data: got %h want 5c", rd_data_o); end
    n_cmp++; if (last_status_o !== 3'd1) begin n_fail++; $display("FAIL seq_status: got %0d want 1", last_status_o); end
    n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL seq_irq: got %b want 1", irq_o); end
    n_cmp++; if (level_o !== '0) begin n_fail++; $display("FAIL seq_level: got %0d want 0", level_o); end
    ack_irq();
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL seq_irq_ack: got %b want 0", irq_o); end
  endtask

  task automatic test_full();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b; exp_t e;
    push_cmd(OP_START, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) push_cmd(OP_WRITE, 8'(8'h10 + i), 1);
    n_cmp++; if (level_o !== LW'(DEPTH)) begin n_fail++; $display("FAIL full_level: got %0d want %0d", level_o, DEPTH); end
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", cmd_ready_o); end
    cmd_valid_i = 1'b1; cmd_op_i = OP_WRITE; cmd_data_i = 8'h99;
    step(); step(); step();
    cmd_valid_i = 1'b0;
    n_cmp++; if (level_o !== LW'(DEPTH)) begin n_fail++; $display("FAIL full_refused: got %0d want %0d", level_o, DEPTH); end
    for (int i = 0; i < 2; i++) begin
      wait_issue(op, d, b);
      e = exp_q.pop_front();
      n_cmp++; if ({op, d} !== {e.op, e.data}) begin
        n_fail++; $display("FAIL full_issue%0d: got op%0d d%h want op%0d d%h", i, op, d, e.op, e.data); end
      respond(2'd0, 8'h00);
    end
    // Sequencer is in IDLE with 7 queued: this edge pops and pushes together.
    n_cmp++; if (cmd_ready_o !== 1'b1 || level_o !== LW'(DEPTH-1)) begin
      n_fail++; $display("FAIL full_pre_pp: ready %b lvl %0d want 1/%0d", cmd_ready_o, level_o, DEPTH-1); end
    cmd_valid_i = 1'b1; cmd_op_i = OP_WRITE; cmd_data_i = 8'h77;
    step();
    cmd_valid_i = 1'b0;
    exp_q.push_back('{op: OP_WRITE, data: 8'h77});
    n_cmp++; if (level_o !== LW'(DEPTH-1) || exec_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL full_push_pop: lvl %0d ev %b want %0d/1", level_o, exec_valid_o, DEPTH-1); end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      wait_issue(op, d, b);
      e = exp_q.pop_front();
      n_cmp++; if ({op, d} !== {e.op, e.data}) begin
        n_fail++; $display("FAIL full_drain%0d: got op%0d d%h want op%0d d%h", i, op, d, e.op, e.data); end
      respond(2'd0, 8'h00);
    end
    n_cmp++; if (level_o !== '0 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL full_end: lvl %0d irq %b want 0/1", level_o, irq_o); end
    ack_irq();
  endtask

  task automatic test_nak_halt();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b;
    push_cmd(OP_START, 8'h00, 0);
    push_cmd(OP_WRITE, 8'h42, 0);
    push_cmd(OP_STOP, 8'h00, 0);
    wait_issue(op, d, b);
    respond(2'd0, 8'h00);
    wait_issue(op, d, b);
    n_cmp++; if ({op, d} !== {OP_WRITE, 8'h42}) begin n_fail++; $display("FAIL nak_issue: got op%0d d%h want op4 d42", op, d); end
    respond(2'd1, 8'h00);
    step(); step(); step();
    n_cmp++; if (last_status_o !== 3'd2) begin n_fail++; $display("FAIL nak_status: got %0d want 2", last_status_o); end
    n_cmp++; if ({halted_o, irq_o, cmd_ready_o, exec_valid_o} !== 4'b1100) begin
      n_fail++; $display("FAIL nak_halt: h%b i%b rdy%b ev%b want 1 1 0 0", halted_o, irq_o, cmd_ready_o, exec_valid_o); end
    n_cmp++; if (level_o !== LW'(1)) begin n_fail++; $display("FAIL nak_level: got %0d want 1", level_o); end
    ack_irq();
    n_cmp++; if ({level_o, halted_o, irq_o} !== '0) begin
      n_fail++; $display("FAIL nak_ack: lvl %0d h %b i %b want 0", level_o, halted_o, irq_o); end
    step(); step(); step();
    n_cmp++; if (exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL nak_flushed: got %b want 0", exec_valid_o); end
  endtask

  task automatic test_bus();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b;
    push_cmd(OP_SET_BUS, 8'd3, 0);
    push_cmd(OP_START, 8'h00, 0);
    wait_issue(op, d, b);
    n_cmp++; if ({op, b} !== {OP_START, 8'd3}) begin n_fail++; $display("FAIL bus_set: got op%0d bus%0d want op0 bus3", op, b); end
    respond(2'd0, 8'h00);
    ack_irq();
    push_cmd(OP_SET_BUS, 8'd16, 0);
    step(); step();
    n_cmp++; if ({halted_o, last_status_o, exec_bus_o} !== {1'b1, 3'd6, 8'd3}) begin
      n_fail++; $display("FAIL bus_bad: h%b st%0d bus%0d want 1 6 3", halted_o, last_status_o, exec_bus_o); end
    ack_irq();
    push_cmd(OP_SET_BUS, 8'd15, 0);
    push_cmd(OP_START, 8'h00, 0);
    wait_issue(op, d, b);
    n_cmp++; if (b !== 8'd15) begin n_fail++; $display("FAIL bus_max: got %0d want 15", b); end
    respond(2'd0, 8'h00);
    ack_irq();
    push_cmd(3'd6, 8'h00, 0);
    step(); step();
    n_cmp++; if ({halted_o, last_status_o} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL bad_op: h%b st%0d want 1 7", halted_o, last_status_o); end
    ack_irq();
  endtask

  task automatic test_timeout();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b;
    push_cmd(OP_START, 8'h00, 0);
    wait_issue(op, d, b);
    repeat (TO-1) step();
    n_cmp++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", halted_o); end
    step();
    n_cmp++; if ({halted_o, last_status_o} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL to_halt: h%b st%0d want 1 5", halted_o, last_status_o); end
    ack_irq();
    push_cmd(OP_START, 8'h00, 0);
    wait_issue(op, d, b);
    repeat (TO-1) step();
    respond(2'd0, 8'h00);
    n_cmp++; if ({halted_o, last_status_o, irq_o} !== {1'b0, 3'd1, 1'b1}) begin
      n_fail++; $display("FAIL to_race: h%b st%0d i%b want 0 1 1", halted_o, last_status_o, irq_o); end
    ack_irq();
  endtask

  task automatic test_reset_mid();
    logic [2:0] op; logic [DW-1:0] d; logic [7:0] b;
    push_cmd(OP_START, 8'h00, 0);
    wait_issue(op, d, b);
    for (int i = 0; i < 5; i++) push_cmd(OP_WRITE, 8'(i), 0);
    n_cmp++; if (level_o !== LW'(5)) begin n_fail++; $display("FAIL rm_level: got %0d want 5", level_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if ({cmd_ready_o, exec_valid_o, halted_o, irq_o, level_o, last_status_o, exec_bus_o, rd_data_o} !== '0) begin
      n_fail++; $display("FAIL rm_async: rdy%b ev%b h%b i%b lvl%0d st%0d bus%0d rd%h want all 0",
        cmd_ready_o, exec_valid_o, halted_o, irq_o, level_o, last_status_o, exec_bus_o, rd_data_o); end
    step();
    rst_n_i = 1'b1;
    step();
    n_cmp++; if (cmd_ready_o !== 1'b1 || level_o !== '0) begin
      n_fail++; $display("FAIL rm_release: rdy%b lvl%0d want 1 0", cmd_ready_o, level_o); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sequence();
    test_full();
    test_nak_halt();
    test_bus();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
